// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and sizing helper for the reset sequencer
package rst_seq_pkg;

    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_RELEASE  = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD     = ST_HOLD,
        S_RELEASE  = ST_RELEASE,
        S_WAIT_ACK = ST_WAIT_ACK,
        S_DONE     = ST_DONE
    } seq_state_t;

    // Bits needed to index v distinct values (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// rtl/rst_seq_timer.sv - loadable saturating down-counter shared by HOLD and WAIT_ACK
module rst_seq_timer #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with per-stage ack or timeout, plus soft re-reset
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sw_rst_req,
    input  logic [N_STAGES-1:0] stage_ack,
    output logic [N_STAGES-1:0] stage_rst,
    output logic                busy,
    output logic                seq_done,
    output logic                timeout_err
);

    localparam int TMAX   = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int TW_RAW = clog2(TMAX);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam int IW_RAW = clog2(N_STAGES);
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_STAGES - 1);

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic          ack_cur;
    logic          t_load;
    logic [TW-1:0] t_val;
    logic          t_dec;
    logic          t_zero;

    assign ack_cur = stage_ack[idx];

    // Soft reset reloads the hold count every cycle it is held, so HOLD restarts after it drops.
    always_comb begin
        t_load = 1'b0;
        t_val  = HOLD_LOAD;
        t_dec  = 1'b0;
        if (sw_rst_req) begin
            t_load = 1'b1;
        end else begin
            case (state)
                S_HOLD:     t_dec = 1'b1;
                S_RELEASE:  begin
                    t_load = 1'b1;
                    t_val  = ACK_LOAD;
                end
                S_WAIT_ACK: t_dec = !ack_cur;
                default:    ;
            endcase
        end
    end

    rst_seq_timer #(
        .W         (TW),
        .RESET_VAL (HOLD_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_HOLD;
            idx         <= '0;
            stage_rst   <= '1;
            busy        <= 1'b1;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else if (sw_rst_req) begin
            state       <= S_HOLD;
            idx         <= '0;
            stage_rst   <= '1;
            busy        <= 1'b1;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (t_zero) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    stage_rst[idx] <= 1'b0;
                    state          <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Ack beats an expiring timer in the same cycle.
                    if (ack_cur || t_zero) begin
                        if (!ack_cur) begin
                            timeout_err <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            seq_done <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_RELEASE;
                        end
                    end
                end
                S_DONE: begin
                    stage_rst <= '0;
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer across three timeout settings
module tb_reset_sequencer;

    logic       clk;
    logic       a_reset, b_reset, c_reset;
    logic       a_sw, b_sw, c_sw;
    logic [3:0] a_ack, b_ack, c_ack;
    logic [3:0] a_rst, b_rst, c_rst;
    logic       a_busy, b_busy, c_busy;
    logic       a_done, b_done, c_done;
    logic       a_terr, b_terr, c_terr;

    int total;
    int bad;

    reset_sequencer #(.N_STAGES(4), .HOLD_CYCLES(16), .ACK_TIMEOUT(255)) dut_a (
        .clk(clk), .reset(a_reset), .sw_rst_req(a_sw), .stage_ack(a_ack),
        .stage_rst(a_rst), .busy(a_busy), .seq_done(a_done), .timeout_err(a_terr)
    );

    reset_sequencer #(.N_STAGES(4), .HOLD_CYCLES(16), .ACK_TIMEOUT(8)) dut_b (
        .clk(clk), .reset(b_reset), .sw_rst_req(b_sw), .stage_ack(b_ack),
        .stage_rst(b_rst), .busy(b_busy), .seq_done(b_done), .timeout_err(b_terr)
    );

    reset_sequencer #(.N_STAGES(4), .HOLD_CYCLES(16), .ACK_TIMEOUT(4)) dut_c (
        .clk(clk), .reset(c_reset), .sw_rst_req(c_sw), .stage_ack(c_ack),
        .stage_rst(c_rst), .busy(c_busy), .seq_done(c_done), .timeout_err(c_terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        a_sw    = 1'b0; b_sw    = 1'b0; c_sw    = 1'b0;
        a_ack   = 4'b0000; b_ack = 4'b0000; c_ack = 4'b0000;
        tick(3);

        // Reset state
        chk("rst_stage_rst", {4'b0, a_rst}, 8'h0F);
        chk("rst_busy",      {7'b0, a_busy}, 8'h01);
        chk("rst_seq_done",  {7'b0, a_done}, 8'h00);
        chk("rst_terr",      {7'b0, a_terr}, 8'h00);

        // Test 1: each stage acks 3 clks after its release
        a_reset = 1'b1;
        tick(16);
        chk("t1_hold_e16",   {4'b0, a_rst}, 8'h0F);
        tick(1);
        chk("t1_rel0_e17",   {4'b0, a_rst}, 8'h0E);
        tick(2);
        a_ack = 4'b0001;
        tick(1);
        chk("t1_e20",        {4'b0, a_rst}, 8'h0E);
        tick(1);
        chk("t1_rel1_e21",   {4'b0, a_rst}, 8'h0C);
        tick(2);
        a_ack = 4'b0011;
        tick(2);
        chk("t1_rel2_e25",   {4'b0, a_rst}, 8'h08);
        tick(2);
        a_ack = 4'b0111;
        tick(2);
        chk("t1_rel3_e29",   {4'b0, a_rst}, 8'h00);
        tick(2);
        chk("t1_busy_e31",   {7'b0, a_busy}, 8'h01);
        chk("t1_ndone_e31",  {7'b0, a_done}, 8'h00);
        a_ack = 4'b1111;
        tick(1);
        chk("t1_done_e32",   {7'b0, a_done}, 8'h01);
        chk("t1_nbusy_e32",  {7'b0, a_busy}, 8'h00);
        chk("t1_terr_e32",   {7'b0, a_terr}, 8'h00);

        // Test 2: acks tied high from reset
        a_reset = 1'b0;
        #1;
        a_reset = 1'b1;
        tick(16);
        chk("t2_hold_e16",   {4'b0, a_rst}, 8'h0F);
        tick(1);
        chk("t2_rel0_e17",   {4'b0, a_rst}, 8'h0E);
        tick(2);
        chk("t2_rel1_e19",   {4'b0, a_rst}, 8'h0C);
        tick(2);
        chk("t2_rel2_e21",   {4'b0, a_rst}, 8'h08);
        tick(2);
        chk("t2_rel3_e23",   {4'b0, a_rst}, 8'h00);
        chk("t2_ndone_e23",  {7'b0, a_done}, 8'h00);
        tick(1);
        chk("t2_done_e24",   {7'b0, a_done}, 8'h01);

        // Test 5: async reset while waiting on stage 1
        a_reset = 1'b0;
        #1;
        a_ack   = 4'b0000;
        a_reset = 1'b1;
        tick(17);
        a_ack = 4'b0001;
        tick(2);
        chk("t5_rel1_e19",   {4'b0, a_rst}, 8'h0C);
        tick(2);
        a_reset = 1'b0;
        #1;
        chk("t5_async_rst",  {4'b0, a_rst}, 8'h0F);
        chk("t5_async_busy", {7'b0, a_busy}, 8'h01);
        a_reset = 1'b1;
        tick(16);
        chk("t5_rehold_e16", {4'b0, a_rst}, 8'h0F);
        tick(1);
        chk("t5_rerel0_e17", {4'b0, a_rst}, 8'h0E);

        // Test 3: stage 2 never acks, timeout of 8
        b_ack   = 4'b1011;
        b_reset = 1'b1;
        tick(21);
        chk("t3_rel2_e21",   {4'b0, b_rst}, 8'h08);
        tick(7);
        chk("t3_nterr_e28",  {7'b0, b_terr}, 8'h00);
        chk("t3_wait_e28",   {4'b0, b_rst}, 8'h08);
        tick(1);
        chk("t3_terr_e29",   {7'b0, b_terr}, 8'h01);
        tick(1);
        chk("t3_rel3_e30",   {4'b0, b_rst}, 8'h00);
        chk("t3_ndone_e30",  {7'b0, b_done}, 8'h00);
        tick(1);
        chk("t3_done_e31",   {7'b0, b_done}, 8'h01);
        chk("t3_terr_e31",   {7'b0, b_terr}, 8'h01);

        // Test 4: one-cycle soft reset from DONE with sticky error set
        b_sw = 1'b1;
        tick(1);
        b_sw = 1'b0;
        chk("t4_sw_rst",     {4'b0, b_rst}, 8'h0F);
        chk("t4_sw_terr",    {7'b0, b_terr}, 8'h00);
        chk("t4_sw_busy",    {7'b0, b_busy}, 8'h01);
        chk("t4_sw_ndone",   {7'b0, b_done}, 8'h00);
        tick(16);
        chk("t4_hold_e16",   {4'b0, b_rst}, 8'h0F);
        tick(1);
        chk("t4_rel0_e17",   {4'b0, b_rst}, 8'h0E);
        tick(12);
        chk("t4_terr_e29",   {7'b0, b_terr}, 8'h01);

        // Soft reset held high for 3 clks: HOLD counts from the drop
        b_sw = 1'b1;
        tick(3);
        chk("t4_held_rst",   {4'b0, b_rst}, 8'h0F);
        b_sw = 1'b0;
        tick(16);
        chk("t4_held_e16",   {4'b0, b_rst}, 8'h0F);
        tick(1);
        chk("t4_held_e17",   {4'b0, b_rst}, 8'h0E);

        // Test 6: ack lands on the timeout cycle, timeout of 4
        c_reset = 1'b1;
        tick(17);
        chk("t6_rel0_e17",   {4'b0, c_rst}, 8'h0E);
        tick(3);
        chk("t6_nterr_e20",  {7'b0, c_terr}, 8'h00);
        c_ack = 4'b0001;
        tick(1);
        chk("t6_nterr_e21",  {7'b0, c_terr}, 8'h00);
        chk("t6_wait_e21",   {4'b0, c_rst}, 8'h0E);
        tick(1);
        chk("t6_rel1_e22",   {4'b0, c_rst}, 8'h0C);
        chk("t6_nterr_e22",  {7'b0, c_terr}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
